// File: rtl/seq161_ctrl.sv
// Sequencing controller for an external 74161-style 4-bit counter: runs a
// programmable-modulus count (16 - preset) for a requested number of wraps.
module seq161_ctrl #(
  parameter int REP_W = 4
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             EN,
  input  logic             req,
  input  logic [3:0]       preset,
  input  logic [REP_W-1:0] reps,
  input  logic             abort,
  input  logic [3:0]       q,
  input  logic             rco,
  output logic             ack,
  output logic             busy,
  output logic             done,
  output logic [REP_W-1:0] wraps,
  output logic             clr_n,
  output logic             ld_n,
  output logic             enp,
  output logic             ent,
  output logic [3:0]       d_out
);

  // state  | meaning
  // IDLE   | waiting for req; counter untouched
  // CLEAR  | clr_n pulse to zero the counter
  // LOAD   | ld_n pulse to load the latched preset
  // RUN    | counting; each rco reloads preset and bumps wraps
  // DONE   | one-cycle done pulse, counter held at preset
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_LOAD,
    ST_RUN,
    ST_DONE
  } state_t;

  localparam logic [REP_W-1:0] REP_ONE = {{(REP_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic             ack_q;
  logic [3:0]       preset_q;
  logic [REP_W-1:0] reps_q;
  logic [REP_W-1:0] wraps_q;
  logic [REP_W-1:0] wraps_inc;
  logic             accept;
  logic             wrap_hit;

  // q is for observation only; the controller decides purely from rco.
  logic unused_q;
  assign unused_q = ^q;

  assign wraps_inc = wraps_q + REP_ONE;

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    wrap_hit = 1'b0;
    clr_n    = 1'b1;
    ld_n     = 1'b1;
    enp      = 1'b0;
    ent      = 1'b0;
    done     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (EN && req) begin
          accept  = 1'b1;
          state_d = (reps == '0) ? ST_DONE : ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        if (EN) begin
          clr_n   = 1'b0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (EN) begin
          ld_n    = 1'b0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (EN) begin
          enp = 1'b1;
          ent = 1'b1;
          // Loading on rco turns the natural 15->0 rollover into 15->preset.
          if (rco) begin
            ld_n     = 1'b0;
            wrap_hit = 1'b1;
            if (wraps_inc == reps_q) begin
              state_d = ST_DONE;
            end
          end
        end
      end
      ST_DONE: begin
        if (EN) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort wins over EN and clears the counter on its way back to idle.
    if (abort && (state_q != ST_IDLE)) begin
      state_d  = ST_IDLE;
      wrap_hit = 1'b0;
      clr_n    = 1'b0;
      ld_n     = 1'b1;
      enp      = 1'b0;
      ent      = 1'b0;
      done     = 1'b0;
    end

    // Hold the counter in clear for as long as reset is asserted.
    if (!RST) begin
      clr_n = 1'b0;
      ld_n  = 1'b1;
      enp   = 1'b0;
      ent   = 1'b0;
      done  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!RST) begin
      state_q  <= ST_IDLE;
      ack_q    <= 1'b0;
      preset_q <= 4'h0;
      reps_q   <= '0;
      wraps_q  <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= accept;
      if (accept) begin
        preset_q <= preset;
        reps_q   <= reps;
        wraps_q  <= '0;
      end else if (wrap_hit) begin
        wraps_q <= wraps_inc;
      end
    end
  end

  assign ack   = ack_q;
  assign busy  = (state_q != ST_IDLE);
  assign wraps = wraps_q;
  assign d_out = RST ? preset_q : 4'h0;

endmodule

// File: tb/tb_seq161_ctrl.sv
// Directed bench for seq161_ctrl driving a behavioural 74161 counter; every
// expected value below is worked out by hand from the command parameters.
module tb_seq161_ctrl;

  logic       clk;
  logic       RST;
  logic       EN;
  logic       req;
  logic [3:0] preset;
  logic [3:0] reps;
  logic       abort;
  logic [3:0] cq;
  logic       rco;
  logic       ack;
  logic       busy;
  logic       done;
  logic [3:0] wraps;
  logic       clr_n;
  logic       ld_n;
  logic       enp;
  logic       ent;
  logic [3:0] d_out;

  int n_chk  = 0;
  int n_pass = 0;

  int s_clr, s_ld, s_ldrun, s_ldmis, s_rco, s_done, s_xack, s_qerr, s_gap, s_run;
  int first_run_k, done_k;
  logic [3:0] q_before;

  seq161_ctrl #(.REP_W(4)) dut (
    .clk    (clk),
    .RST    (RST),
    .EN     (EN),
    .req    (req),
    .preset (preset),
    .reps   (reps),
    .abort  (abort),
    .q      (cq),
    .rco    (rco),
    .ack    (ack),
    .busy   (busy),
    .done   (done),
    .wraps  (wraps),
    .clr_n  (clr_n),
    .ld_n   (ld_n),
    .enp    (enp),
    .ent    (ent),
    .d_out  (d_out)
  );

  // 74161: clear beats load beats count.
  always @(posedge clk) begin
    if (!clr_n)          cq <= 4'h0;
    else if (!ld_n)      cq <= d_out;
    else if (enp && ent) cq <= cq + 4'd1;
  end
  assign rco = (cq == 4'hF) && ent;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic do_cmd(input logic [3:0] p, input logic [3:0] r,
                        input int gap_at, input int abort_after, input bit pulse_req);
    int gap_left;
    bit gap_done, post, ab_done, ab_now, ab_post, finished, run_started;
    logic [3:0] eq;
    s_clr = 0; s_ld = 0; s_ldrun = 0; s_ldmis = 0; s_rco = 0; s_done = 0;
    s_xack = 0; s_qerr = 0; s_gap = 0; s_run = 0; first_run_k = -1; done_k = -1;
    gap_left = 0; gap_done = 0; post = 0; ab_done = 0; ab_now = 0; ab_post = 0;
    finished = 0; run_started = 0; eq = p;
    @(negedge clk);
    q_before = cq;
    req = 1'b1; preset = p; reps = r;
    @(negedge clk);
    req = 1'b0;
    #1;
    chk("ack_after_req", ack, 1);
    for (int k = 0; k < 120; k++) begin
      if (k > 0) begin
        @(negedge clk);
        ab_now = (abort_after > 0) && !ab_done && (s_rco >= abort_after);
        if (ab_now) ab_done = 1;
        abort = ab_now;
        req = pulse_req && (k == 6);
        if (gap_left > 0) begin
          gap_left--;
          EN = (gap_left == 0);
        end else if (gap_at >= 0 && !gap_done && s_run == gap_at) begin
          EN = 1'b0;
          gap_left = 5;
          gap_done = 1;
        end
        #1;
      end
      if (post) begin
        chk("busy_after_done", busy, 0);
        finished = 1;
        break;
      end
      if (ab_post) begin
        chk("q_after_abort", cq, 0);
        chk("busy_after_abort", busy, 0);
        finished = 1;
        break;
      end
      if (ab_now) begin
        chk("abort_clr_n", clr_n, 0);
        chk("abort_ld_n", ld_n, 1);
        chk("abort_enp", enp, 0);
        chk("abort_done", done, 0);
        ab_post = 1;
      end
      if (enp) begin
        if (!run_started) begin
          run_started = 1;
          first_run_k = k;
        end
        s_run++;
        if (cq !== eq) s_qerr++;
        if (rco !== !ld_n) s_ldmis++;
        if (!ld_n) s_ldrun++;
        eq = rco ? p : eq + 4'd1;
      end else if (run_started && !EN && !done) begin
        s_gap++;
        if (cq !== eq) s_qerr++;
      end
      if (!clr_n) s_clr++;
      if (!ld_n) s_ld++;
      if (rco) s_rco++;
      if (k > 0 && ack) s_xack++;
      if (done) begin
        s_done++;
        done_k = k;
        post = 1;
      end
    end
    abort = 1'b0;
    req = 1'b0;
    EN = 1'b1;
    if (!finished) chk("cmd_timeout", 0, 1);
  endtask

  initial begin
    RST = 1'b0; EN = 1'b1; req = 1'b1; preset = 4'd3; reps = 4'd2; abort = 1'b0;

    // reset held with a pending request
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_clr_n", clr_n, 0);
    chk("rst_q", cq, 0);
    chk("rst_d_out", d_out, 0);
    @(negedge clk);
    RST = 1'b1; req = 1'b0;
    #1;
    chk("idle_clr_n", clr_n, 1);
    chk("idle_ld_n", ld_n, 1);
    chk("idle_enp", enp, 0);
    chk("idle_ent", ent, 0);
    chk("idle_done", done, 0);
    chk("idle_wraps", wraps, 0);
    chk("idle_busy", busy, 0);

    // modulus 4, three wraps
    do_cmd(4'd12, 4'd3, -1, 0, 0);
    chk("p12_done_cnt", s_done, 1);
    chk("p12_done_k", done_k, 14);
    chk("p12_run_len", done_k - first_run_k, 12);
    chk("p12_rco", s_rco, 3);
    chk("p12_ld_run", s_ldrun, 3);
    chk("p12_ld_mis", s_ldmis, 0);
    chk("p12_clr", s_clr, 1);
    chk("p12_q_seq", s_qerr, 0);
    chk("p12_wraps", wraps, 3);
    chk("p12_q_end", cq, 12);
    chk("p12_xack", s_xack, 0);

    // modulus 1: rco every RUN cycle
    do_cmd(4'd15, 4'd2, -1, 0, 0);
    chk("p15_done_k", done_k, 4);
    chk("p15_run_len", done_k - first_run_k, 2);
    chk("p15_rco", s_rco, 2);
    chk("p15_done_cnt", s_done, 1);
    chk("p15_wraps", wraps, 2);
    chk("p15_q_end", cq, 15);

    // EN low in idle blocks acceptance
    @(negedge clk);
    EN = 1'b0; req = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("en0_ack", ack, 0);
    chk("en0_busy", busy, 0);
    @(negedge clk);
    req = 1'b0; EN = 1'b1;

    // zero repetitions: straight to DONE
    do_cmd(4'd5, 4'd0, -1, 0, 0);
    chk("r0_done_k", done_k, 0);
    chk("r0_clr", s_clr, 0);
    chk("r0_ld", s_ld, 0);
    chk("r0_run", s_run, 0);
    chk("r0_q_same", cq, q_before);
    chk("r0_wraps", wraps, 0);
    chk("r0_d_out", d_out, 5);

    // full modulus with a five-cycle EN gap mid-RUN
    do_cmd(4'd0, 4'd1, 4, 0, 0);
    chk("gap_cycles", s_gap, 5);
    chk("gap_run_len", done_k - first_run_k, 21);
    chk("gap_done_k", done_k, 23);
    chk("gap_q_seq", s_qerr, 0);
    chk("gap_done_cnt", s_done, 1);
    chk("gap_wraps", wraps, 1);
    chk("gap_q_end", cq, 0);

    // abort after the first wrap, with a req pulse while busy
    do_cmd(4'd8, 4'd4, -1, 1, 1);
    chk("ab_done_cnt", s_done, 0);
    chk("ab_xack", s_xack, 0);
    chk("ab_wraps", wraps, 1);
    chk("ab_clr", s_clr, 2);
    chk("ab_q_seq", s_qerr, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
